// File: rtl/lives_sequencer_pkg.sv
// Shared types, arbitration order and lives arithmetic for the lives sequencer.
package lives_pkg;

  localparam int LIVES_W = 4;

  typedef enum logic [2:0] {
    ALIVE,
    DYING,
    RESPAWN,
    INVULN,
    GAME_OVER
  } lives_state_t;

  // Request priority order: a lower index wins when several requests arrive together.
  localparam int PRIO_RESET   = 0;
  localparam int PRIO_HIT     = 1;
  localparam int PRIO_POWERUP = 2;
  localparam int PRIO_SW_DEC  = 3;
  localparam int PRIO_SW_INC  = 4;
  localparam int NUM_REQ      = 5;

  // Add one life, never exceeding the ceiling.
  function automatic logic [LIVES_W-1:0] sat_inc(input logic [LIVES_W-1:0] v,
                                                 input logic [LIVES_W-1:0] ceil);
    return (v >= ceil) ? ceil : v + 1'b1;
  endfunction

endpackage

// File: rtl/lives_sequencer_if.sv
// Event and status bundle between game logic and the lives sequencer.
interface lives_sequencer_if;
  import lives_pkg::*;

  logic               startOfFrame;
  logic [1:0]         player_hit;
  logic               powerUp_inc;
  logic               sw_inc;
  logic               sw_dec;
  logic               score_reset;
  logic [LIVES_W-1:0] lives;
  logic               player_died;
  logic               invulnerable;
  logic               player_blink;
  logic               respawn_pulse;
  logic               hit_ack;

  // Game logic side: raises events, watches lives status.
  modport master (
    output startOfFrame, player_hit, powerUp_inc, sw_inc, sw_dec, score_reset,
    input  lives, player_died, invulnerable, player_blink, respawn_pulse, hit_ack
  );

  // Sequencer side: consumes events, owns lives status.
  modport slave (
    input  startOfFrame, player_hit, powerUp_inc, sw_inc, sw_dec, score_reset,
    output lives, player_died, invulnerable, player_blink, respawn_pulse, hit_ack
  );
endinterface

// File: rtl/lives_sequencer_edge_detect_rise.sv
// Rising-edge detector for a level input such as a debug switch.
module edge_detect_rise (
  input  logic clk,
  input  logic resetN,
  input  logic level_i,
  output logic rise_o
);
  logic prev_q;

  // Remember last cycle's level.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) prev_q <= 1'b0;
    else         prev_q <= level_i;
  end

  assign rise_o = level_i & ~prev_q;
endmodule

// File: rtl/lives_sequencer.sv
// Lives counter with hit / power-up / switch arbitration and the
// death -> respawn -> invulnerability sequence timed by frame ticks.
module lives_sequencer
  import lives_pkg::*;
#(
  parameter int MAX_LIVES     = 3,
  parameter int INIT_LIVES    = 3,
  parameter int DEATH_FRAMES  = 60,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input logic              clk,
  input logic              resetN,
  lives_sequencer_if.slave bus
);
  localparam int MAX_FRAMES = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  localparam logic [LIVES_W-1:0] MAX_L       = LIVES_W'(MAX_LIVES);
  localparam logic [LIVES_W-1:0] INIT_L      = LIVES_W'(INIT_LIVES);
  localparam logic [CNT_W-1:0]   DEATH_LAST  = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0]   INVULN_LAST = CNT_W'(INVULN_FRAMES - 1);

  lives_state_t       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               pend_q, pend_d;
  logic               ack_q, ack_d;

  logic               inc_rise, dec_rise;
  logic               in_play;
  logic [NUM_REQ-1:0] req;
  int                 win;
  logic               blink_even;

  edge_detect_rise u_edge_inc (
    .clk    (clk),
    .resetN (resetN),
    .level_i(bus.sw_inc),
    .rise_o (inc_rise)
  );

  edge_detect_rise u_edge_dec (
    .clk    (clk),
    .resetN (resetN),
    .level_i(bus.sw_dec),
    .rise_o (dec_rise)
  );

  assign in_play = (state_q == ALIVE) || (state_q == INVULN);

  // Collect requests that are meaningful in the current state; ignored hits do not block others.
  always_comb begin
    req               = '0;
    req[PRIO_RESET]   = bus.score_reset;
    req[PRIO_HIT]     = (|bus.player_hit) && (state_q == ALIVE);
    req[PRIO_POWERUP] = bus.powerUp_inc && (state_q != GAME_OVER);
    req[PRIO_SW_DEC]  = dec_rise && in_play && (lives_q != '0);
    req[PRIO_SW_INC]  = inc_rise && in_play;
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ALIVE;
      cnt_q   <= '0;
      lives_q <= INIT_L;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lives_q <= lives_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
    end
  end

  // Timer-driven progression first, then the single winning lives request overrides it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;

    win = NUM_REQ;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) win = i;
    end

    case (state_q)
      DYING: begin
        if (bus.startOfFrame) begin
          if (cnt_q == DEATH_LAST) begin
            state_d = RESPAWN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RESPAWN: begin
        // A power-up collected while dead is granted as invulnerability starts.
        state_d = INVULN;
        cnt_d   = '0;
        pend_d  = 1'b0;
        if (pend_q || bus.powerUp_inc) lives_d = sat_inc(lives_q, MAX_L);
      end
      INVULN: begin
        if (bus.startOfFrame) begin
          if (cnt_q == INVULN_LAST) begin
            state_d = ALIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      GAME_OVER: lives_d = '0;
      default: ;
    endcase

    case (win)
      PRIO_RESET: begin
        state_d = ALIVE;
        cnt_d   = '0;
        lives_d = INIT_L;
        pend_d  = 1'b0;
      end
      PRIO_HIT: begin
        ack_d = 1'b1;
        cnt_d = '0;
        if (lives_q > 4'd1) begin
          lives_d = lives_q - 1'b1;
          state_d = DYING;
          pend_d  = bus.powerUp_inc;
        end else begin
          lives_d = '0;
          state_d = GAME_OVER;
        end
      end
      PRIO_POWERUP: begin
        if (in_play)                lives_d = sat_inc(lives_q, MAX_L);
        else if (state_q == DYING)  pend_d  = 1'b1;
      end
      PRIO_SW_DEC: begin
        if (lives_q == 4'd1) begin
          lives_d = '0;
          state_d = GAME_OVER;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else begin
          lives_d = lives_q - 1'b1;
        end
      end
      PRIO_SW_INC: lives_d = sat_inc(lives_q, MAX_L);
      default: ;
    endcase
  end

  // Blink phase: visible during the first BLINK_FRAMES ticks of invulnerability, then alternating.
  assign blink_even = ((32'(cnt_q) / BLINK_FRAMES) % 2) == 0;

  assign bus.lives         = lives_q;
  assign bus.player_died   = (state_q == GAME_OVER);
  assign bus.invulnerable  = (state_q == DYING) || (state_q == RESPAWN) || (state_q == INVULN);
  assign bus.player_blink  = (state_q == DYING)  ? 1'b0 :
                             (state_q == INVULN) ? blink_even : 1'b1;
  assign bus.respawn_pulse = (state_q == RESPAWN);
  assign bus.hit_ack       = ack_q;
endmodule

// File: tb/tb_lives_sequencer.sv
// Bench for lives_sequencer: fixed vector table, hand-written sequences, random run vs model.
module tb_lives_sequencer;
  localparam int MAX_LIVES     = 3;
  localparam int INIT_LIVES    = 3;
  localparam int DEATH_FRAMES  = 60;
  localparam int INVULN_FRAMES = 120;
  localparam int BLINK_FRAMES  = 8;

  localparam int M_ALIVE = 0, M_DYING = 1, M_RESPAWN = 2, M_INVULN = 3, M_OVER = 4;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  lives_sequencer_if bus();

  lives_sequencer #(
    .MAX_LIVES    (MAX_LIVES),
    .INIT_LIVES   (INIT_LIVES),
    .DEATH_FRAMES (DEATH_FRAMES),
    .INVULN_FRAMES(INVULN_FRAMES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: mode plus a countdown of frames remaining in the timed phase.
  int m_lives, m_mode, m_left;
  bit m_pend, m_ack, m_pinc, m_pdec;

  typedef struct {
    bit       sof;
    bit [1:0] hit;
    bit       pup;
    bit       inc;
    bit       dec;
    bit       srst;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [8:0] exp_of(int l, int d, int inv, int b, int r, int a);
    return {4'(l), 1'(d), 1'(inv), 1'(b), 1'(r), 1'(a)};
  endfunction

  function automatic vec_t mkv(int sof, int hit, int pup, int inc, int dec, int srst, logic [8:0] e);
    vec_t v;
    v.sof = 1'(sof); v.hit = 2'(hit); v.pup = 1'(pup);
    v.inc = 1'(inc); v.dec = 1'(dec); v.srst = 1'(srst); v.exp = e;
    return v;
  endfunction

  function automatic int up1(int v);
    return (v + 1 > MAX_LIVES) ? MAX_LIVES : v + 1;
  endfunction

  task automatic model_reset();
    m_lives = INIT_LIVES; m_mode = M_ALIVE; m_left = 0;
    m_pend = 0; m_ack = 0; m_pinc = 0; m_pdec = 0;
  endtask

  task automatic model_step(bit sof, bit [1:0] hit, bit pup, bit inc, bit dec, bit srst);
    bit ie, de, active;
    int nm;
    ie = inc && !m_pinc;
    de = dec && !m_pdec;
    m_pinc = inc;
    m_pdec = dec;
    m_ack = 0;
    if (srst) begin
      m_lives = INIT_LIVES; m_mode = M_ALIVE; m_pend = 0; m_left = 0;
      return;
    end
    nm = m_mode;
    if (m_mode == M_DYING && sof) begin
      m_left = m_left - 1;
      if (m_left == 0) nm = M_RESPAWN;
    end else if (m_mode == M_RESPAWN) begin
      nm = M_INVULN;
      m_left = INVULN_FRAMES;
      if (m_pend || pup) m_lives = up1(m_lives);
      m_pend = 0;
    end else if (m_mode == M_INVULN && sof) begin
      m_left = m_left - 1;
      if (m_left == 0) nm = M_ALIVE;
    end
    active = (m_mode == M_ALIVE) || (m_mode == M_INVULN);
    if (hit != 2'b00 && m_mode == M_ALIVE) begin
      m_ack = 1;
      if (m_lives > 1) begin
        m_lives = m_lives - 1; nm = M_DYING; m_left = DEATH_FRAMES; m_pend = pup;
      end else begin
        m_lives = 0; nm = M_OVER;
      end
    end else if (pup && m_mode != M_OVER) begin
      if (active) m_lives = up1(m_lives);
      else if (m_mode == M_DYING) m_pend = 1;
    end else if (de && active && m_lives > 0) begin
      m_lives = m_lives - 1;
      if (m_lives == 0) nm = M_OVER;
    end else if (ie && active) begin
      m_lives = up1(m_lives);
    end
    m_mode = nm;
  endtask

  function automatic logic [8:0] model_out();
    int b;
    if (m_mode == M_DYING)       b = 0;
    else if (m_mode == M_INVULN) b = (((INVULN_FRAMES - m_left) / BLINK_FRAMES) % 2 == 0) ? 1 : 0;
    else                         b = 1;
    return exp_of(m_lives, m_mode == M_OVER,
                  m_mode == M_DYING || m_mode == M_RESPAWN || m_mode == M_INVULN,
                  b, m_mode == M_RESPAWN, m_ack);
  endfunction

  function automatic logic [8:0] dut_out();
    return {bus.lives, bus.player_died, bus.invulnerable, bus.player_blink,
            bus.respawn_pulse, bus.hit_ack};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, compare all outputs after the edge.
  task automatic step(bit sof, bit [1:0] hit, bit pup, bit inc, bit dec, bit srst);
    bus.startOfFrame = sof;
    bus.player_hit   = hit;
    bus.powerUp_inc  = pup;
    bus.sw_inc       = inc;
    bus.sw_dec       = dec;
    bus.score_reset  = srst;
    model_step(sof, hit, pup, inc, dec, srst);
    @(posedge clk);
    #1;
    check("model_cycle", 32'(dut_out()), 32'(model_out()));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  ticks;
    bit  found, done, seen;
    bit  r_inc, r_dec;

    tbl[0]  = mkv(0, 0, 0, 0, 0, 0, exp_of(3, 0, 0, 1, 0, 0));
    tbl[1]  = mkv(0, 0, 1, 0, 0, 0, exp_of(3, 0, 0, 1, 0, 0));
    tbl[2]  = mkv(0, 0, 0, 0, 1, 0, exp_of(2, 0, 0, 1, 0, 0));
    tbl[3]  = mkv(0, 0, 0, 0, 1, 0, exp_of(2, 0, 0, 1, 0, 0));
    tbl[4]  = mkv(0, 0, 0, 0, 0, 0, exp_of(2, 0, 0, 1, 0, 0));
    tbl[5]  = mkv(0, 0, 0, 1, 0, 0, exp_of(3, 0, 0, 1, 0, 0));
    tbl[6]  = mkv(0, 0, 0, 0, 0, 0, exp_of(3, 0, 0, 1, 0, 0));
    tbl[7]  = mkv(0, 1, 0, 0, 0, 0, exp_of(2, 0, 1, 0, 0, 1));
    tbl[8]  = mkv(0, 3, 0, 0, 0, 0, exp_of(2, 0, 1, 0, 0, 0));
    tbl[9]  = mkv(0, 0, 1, 0, 0, 0, exp_of(2, 0, 1, 0, 0, 0));
    tbl[10] = mkv(0, 3, 1, 0, 0, 1, exp_of(3, 0, 0, 1, 0, 0));
    tbl[11] = mkv(1, 0, 0, 0, 0, 0, exp_of(3, 0, 0, 1, 0, 0));
    tbl[12] = mkv(0, 2, 1, 0, 0, 0, exp_of(2, 0, 1, 0, 0, 1));
    tbl[13] = mkv(0, 0, 0, 0, 0, 1, exp_of(3, 0, 0, 1, 0, 0));
    tbl[14] = mkv(0, 0, 0, 1, 1, 0, exp_of(2, 0, 0, 1, 0, 0));
    tbl[15] = mkv(0, 0, 0, 0, 0, 0, exp_of(2, 0, 0, 1, 0, 0));

    resetN = 1'b0;
    bus.startOfFrame = 0; bus.player_hit = 0; bus.powerUp_inc = 0;
    bus.sw_inc = 0; bus.sw_dec = 0; bus.score_reset = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(dut_out()), 32'(exp_of(INIT_LIVES, 0, 0, 1, 0, 0)));
    resetN = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].sof, tbl[i].hit, tbl[i].pup, tbl[i].inc, tbl[i].dec, tbl[i].srst);
      check($sformatf("table_row_%0d", i), 32'(dut_out()), 32'(tbl[i].exp));
    end

    // Full death sequence with a power-up banked while dying.
    step(0, 2'b00, 0, 0, 0, 1);
    step(0, 2'b01, 0, 0, 0, 0);
    check("A_hit_ack", 32'(bus.hit_ack), 1);
    check("A_lives_after_hit", 32'(bus.lives), 2);
    step(0, 2'b00, 1, 0, 0, 0);
    check("A_pending_held", 32'(bus.lives), 2);
    found = 0; ticks = 0;
    for (int i = 1; i <= 200 && !found; i++) begin
      step(1, 2'b00, 0, 0, 0, 0);
      if (bus.respawn_pulse) begin found = 1; ticks = i; end
    end
    check("A_death_ticks", 32'(ticks), 32'(DEATH_FRAMES));
    check("A_lives_at_respawn", 32'(bus.lives), 2);
    step(0, 2'b00, 0, 0, 0, 0);
    check("A_respawn_one_cycle", 32'(bus.respawn_pulse), 0);
    check("A_pending_applied", 32'(bus.lives), 3);
    step(0, 2'b01, 0, 0, 0, 0);
    check("A_invuln_hit_ack", 32'(bus.hit_ack), 0);
    check("A_invuln_hit_lives", 32'(bus.lives), 3);
    found = 0; ticks = 0;
    for (int i = 1; i <= 300 && !found; i++) begin
      step(1, 2'b00, 0, 0, 0, 0);
      if (!bus.invulnerable) begin found = 1; ticks = i; end
    end
    check("A_invuln_ticks", 32'(ticks), 32'(INVULN_FRAMES));
    step(0, 2'b00, 1, 0, 0, 0);
    check("A_powerup_saturate", 32'(bus.lives), 3);
    step(0, 2'b11, 0, 0, 0, 0);
    check("A_double_hit_ack", 32'(bus.hit_ack), 1);
    check("A_double_hit_lives", 32'(bus.lives), 2);
    step(0, 2'b00, 0, 0, 0, 0);
    check("A_single_ack", 32'(bus.hit_ack), 0);
    check("A_single_decrement", 32'(bus.lives), 2);

    // Three hits to game over; game over is sticky until score_reset.
    step(0, 2'b00, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 2'b01, 0, 0, 0, 0);
      if (k < 2) begin
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
          step(1, 2'b00, 0, 0, 0, 0);
          if (!bus.invulnerable) done = 1;
        end
        check($sformatf("B_sequence_%0d_done", k), 32'(done), 1);
      end
    end
    check("B_lives_zero", 32'(bus.lives), 0);
    check("B_died", 32'(bus.player_died), 1);
    step(1, 2'b11, 1, 1, 0, 0);
    check("B_over_lives_held", 32'(bus.lives), 0);
    check("B_over_no_ack", 32'(bus.hit_ack), 0);
    step(0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 1);
    check("B_restart_lives", 32'(bus.lives), 3);
    check("B_restart_died", 32'(bus.player_died), 0);
    check("B_restart_alive", 32'(bus.invulnerable), 0);

    // Held debug switch gives one step; further presses reach game over without dying.
    step(0, 2'b00, 0, 0, 0, 1);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 2'b00, 0, 0, 1, 0);
      if (bus.invulnerable || bus.respawn_pulse) seen = 1;
    end
    check("C_hold_one_step", 32'(bus.lives), 2);
    step(0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 1, 0);
    if (bus.invulnerable || bus.respawn_pulse) seen = 1;
    step(0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 1, 0);
    if (bus.invulnerable || bus.respawn_pulse) seen = 1;
    check("C_lives_zero", 32'(bus.lives), 0);
    check("C_game_over", 32'(bus.player_died), 1);
    check("C_no_death_sequence", 32'(seen), 0);

    // Asynchronous reset in the middle of invulnerability.
    step(0, 2'b00, 0, 0, 0, 1);
    step(0, 2'b01, 0, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1, 2'b00, 0, 0, 0, 0);
      if (bus.respawn_pulse) found = 1;
    end
    check("D_reached_respawn", 32'(found), 1);
    repeat (5) step(1, 2'b00, 0, 0, 0, 0);
    check("D_in_invuln", 32'(bus.invulnerable), 1);
    #2;
    resetN = 1'b0;
    #1;
    check("D_async_reset_outputs", 32'(dut_out()), 32'(exp_of(INIT_LIVES, 0, 0, 1, 0, 0)));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;

    // Random traffic against the model.
    r_inc = 0; r_dec = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) r_inc = ~r_inc;
      if ($urandom_range(15) == 0) r_dec = ~r_dec;
      step($urandom_range(1) == 1,
           ($urandom_range(39) == 0) ? 2'($urandom_range(3, 1)) : 2'b00,
           $urandom_range(29) == 0, r_inc, r_dec,
           $urandom_range(149) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
